// File: rtl/booth_mult_seq_if.sv
// -----------------------------------------------------------------------------
// booth_mult_seq_if
//
// Bundles the handshake and data signals between the multdiv wrapper and the
// iterative radix-4 Booth multiplier datapath. Clock and reset stay as plain
// module ports.
//
// Signals
//   ctrl_MULT       wrapper -> mult   start request (sampled only when idle/done)
//   data_operandA   wrapper -> mult   signed multiplicand
//   shift_in        wrapper -> mult   per-group: magnitude 2M when 1, M when 0
//   sub_in          wrapper -> mult   per-group: negate partial product when 1
//   nothing_in      wrapper -> mult   per-group: partial product is 0 when 1
//   data_result     mult -> wrapper   low WIDTH bits of the signed product
//   data_exception  mult -> wrapper   signed overflow of the WIDTH-bit result
//   data_resultRDY  mult -> wrapper   one-cycle pulse, result/exception valid
//   busy            mult -> wrapper   high while groups are being accumulated
//
// Modports
//   master : the side that issues operations (wrapper / testbench)
//   slave  : the multiplier
// -----------------------------------------------------------------------------
interface booth_mult_seq_if #(
  parameter int NGROUPS = 16,
  parameter int WIDTH   = 32
);

  logic               ctrl_MULT;
  logic [WIDTH-1:0]   data_operandA;
  logic [NGROUPS-1:0] shift_in;
  logic [NGROUPS-1:0] sub_in;
  logic [NGROUPS-1:0] nothing_in;
  logic [WIDTH-1:0]   data_result;
  logic               data_exception;
  logic               data_resultRDY;
  logic               busy;

  modport master (
    output ctrl_MULT,
    output data_operandA,
    output shift_in,
    output sub_in,
    output nothing_in,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  ctrl_MULT,
    input  data_operandA,
    input  shift_in,
    input  sub_in,
    input  nothing_in,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output busy
  );

endinterface : booth_mult_seq_if

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
//
// Iterative radix-4 Booth multiplier datapath. The Booth decoder for operand B
// has already produced one SHIFT/SUB/NOTHING control triple per 2-bit group;
// this block latches those vectors together with the multiplicand A and adds
// one partial product per clock into a 66-bit signed accumulator, lowest group
// first. After the last group it publishes the low WIDTH bits of the product,
// a signed-overflow flag and a one-cycle ready pulse.
//
// Ports
//   clock   input   rising-edge system clock
//   reset   input   asynchronous, active-high reset; aborts a running operation
//   bus     slave   booth_mult_seq_if (see interface header for signal list)
//
// Timing (default build)
//   Start accepted at edge k -> groups 0..15 accumulated on edges k+1..k+16
//   -> data_resultRDY high in the cycle after edge k+16, low after edge k+17.
//   Holding ctrl_MULT high in DONE chains operations at one per 17 cycles.
//
// Configuration
//   BOOTH_EARLY_EXIT_EN  when defined, RUN ends as soon as every remaining
//                        group is NOTHING (minimum one RUN cycle). Results and
//                        flags are unchanged; only latency shrinks.
//                        Undefined (default): always 16 RUN cycles.
// -----------------------------------------------------------------------------
module booth_mult_seq #(
  parameter int NGROUPS = 16,
  parameter int WIDTH   = 32
) (
  input  logic           clock,
  input  logic           reset,
  booth_mult_seq_if.slave bus
);

  // Accumulator is wide enough for the full 2*WIDTH product plus headroom for
  // the +/-2M partial product of the top group before the sum settles.
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int CNT_W = $clog2(NGROUPS);
  localparam int SH_W  = CNT_W + 1;

  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NGROUPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,   state_d;
  logic [ACC_W-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic [ACC_W-1:0]   a_q,       a_d;
  logic [NGROUPS-1:0] shift_q,   shift_d;
  logic [NGROUPS-1:0] sub_q,     sub_d;
  logic [NGROUPS-1:0] nothing_q, nothing_d;
  logic [WIDTH-1:0]   result_q,  result_d;
  logic               exc_q,     exc_d;

  // ---------------------------------------------------------------------------
  // Partial product for the group selected by count_q
  // ---------------------------------------------------------------------------
  logic             grp_shift;
  logic             grp_sub;
  logic             grp_nothing;
  logic [ACC_W-1:0] pp_mag;
  logic [ACC_W-1:0] pp_signed;
  logic [ACC_W-1:0] pp_aligned;
  logic [ACC_W-1:0] acc_sum;
  logic [SH_W-1:0]  pp_shamt;

  always_comb begin
    grp_shift   = shift_q[count_q];
    grp_sub     = sub_q[count_q];
    grp_nothing = nothing_q[count_q];

    pp_mag = grp_shift ? (a_q << 1) : a_q;

    // NOTHING wins over SHIFT and SUB so a 000/111 group contributes exactly 0
    // regardless of what the other two vectors carry for that group.
    if (grp_nothing) begin
      pp_signed = '0;
    end else if (grp_sub) begin
      pp_signed = -pp_mag;
    end else begin
      pp_signed = pp_mag;
    end

    // Group g carries weight 4^g.
    pp_shamt   = {count_q, 1'b0};
    pp_aligned = pp_signed << pp_shamt;
    acc_sum    = acc_q + pp_aligned;
  end

  // ---------------------------------------------------------------------------
  // End-of-run detection
  // ---------------------------------------------------------------------------
  logic last_group;
  logic finish_run;

  assign last_group = (count_q == LAST_GROUP);

`ifdef BOOTH_EARLY_EXIT_EN
  // True when every group above the one being accumulated now is NOTHING, so
  // the accumulator already holds the final product.
  logic rest_nothing;

  always_comb begin
    rest_nothing = 1'b1;
    for (int i = 0; i < NGROUPS; i++) begin
      if ((i > int'(count_q)) && !nothing_q[i]) begin
        rest_nothing = 1'b0;
      end
    end
  end

  assign finish_run = last_group || rest_nothing;
`else
  assign finish_run = last_group;
`endif

  // ---------------------------------------------------------------------------
  // Overflow: the product fits signed WIDTH bits only when bits
  // [2*WIDTH-1 : WIDTH-1] of the final sum are all copies of the sign bit.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] hi_bits;
  logic           sum_overflow;

  assign hi_bits      = acc_sum[2*WIDTH-1:WIDTH-1];
  assign sum_overflow = ~((&hi_bits) | (~|hi_bits));

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    a_d       = a_q;
    shift_d   = shift_q;
    sub_d     = sub_q;
    nothing_d = nothing_q;
    result_d  = result_q;
    exc_d     = exc_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.ctrl_MULT) begin
          state_d   = ST_RUN;
          a_d       = ACC_W'($signed(bus.data_operandA));
          shift_d   = bus.shift_in;
          sub_d     = bus.sub_in;
          nothing_d = bus.nothing_in;
          acc_d     = '0;
          count_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // ctrl_MULT is deliberately not looked at here.
        acc_d   = acc_sum;
        count_d = count_q + CNT_W'(1);
        if (finish_run) begin
          state_d  = ST_DONE;
          result_d = acc_sum[WIDTH-1:0];
          exc_d    = sum_overflow;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: the latched operand and control vectors are ordinary registers, not a
  // memory, so they are cleared with everything else on reset; that keeps the
  // datapath free of X after reset even though their contents are reloaded
  // before use.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      a_q       <= '0;
      shift_q   <= '0;
      sub_q     <= '0;
      nothing_q <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values of the others, independent of statement order.
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      a_q       <= a_d;
      shift_q   <= shift_d;
      sub_q     <= sub_d;
      nothing_q <= nothing_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // DONE lasts exactly one cycle, so decoding it gives the one-cycle ready
  // pulse; reset drops it immediately through the state register.
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == ST_DONE);
  assign bus.busy           = (state_q == ST_RUN);

endmodule : booth_mult_seq

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
//
// Self-checking bench for booth_mult_seq. Operand B is turned into Booth
// control vectors by a decoder model in the bench (junk SHIFT/SUB bits are
// placed in NOTHING groups). Expected results come from a table of constants
// or from plain 64-bit signed multiplication. Expected latency comes from the
// group count, or, with BOOTH_EARLY_EXIT_EN, from the highest non-NOTHING
// group.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  booth_mult_seq_if bus ();

  booth_mult_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Radix-4 Booth decoder: group g looks at B bits {2g+1, 2g, 2g-1}.
  task automatic encode(input logic [31:0] b, output logic [15:0] sh,
                        output logic [15:0] su, output logic [15:0] no);
    logic [32:0] bx;
    logic [2:0]  t;
    bx = {b, 1'b0};
    for (int g = 0; g < 16; g++) begin
      t = bx[2*g+2 -: 3];
      case (t)
        3'b000, 3'b111: begin
          no[g] = 1'b1;
          sh[g] = 1'($urandom);
          su[g] = 1'($urandom);
        end
        3'b001, 3'b010: begin no[g] = 1'b0; sh[g] = 1'b0; su[g] = 1'b0; end
        3'b011:         begin no[g] = 1'b0; sh[g] = 1'b1; su[g] = 1'b0; end
        3'b100:         begin no[g] = 1'b0; sh[g] = 1'b1; su[g] = 1'b1; end
        default:        begin no[g] = 1'b0; sh[g] = 1'b0; su[g] = 1'b1; end
      endcase
    end
  endtask

  function automatic int exp_lat(input logic [15:0] no);
`ifdef BOOTH_EARLY_EXIT_EN
    int h = 0;
    for (int i = 0; i < 16; i++) begin
      if (!no[i]) h = i;
    end
    return h + 1;
`else
    return 16;
`endif
  endfunction

  task automatic ref_mult(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic e);
    longint p;
    logic [63:0] pv;
    p  = longint'($signed(a)) * longint'($signed(b));
    pv = p;
    r  = pv[31:0];
    e  = (p != longint'($signed(pv[31:0])));
  endtask

  // One complete operation with latency, busy, hold and pulse-width checks.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input bit pulse_mid);
    logic [15:0] sh, su, no;
    logic [31:0] prev;
    int lat, busy_n, el;
    bit held;
    encode(b, sh, su, no);
    el = exp_lat(no);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.shift_in      = sh;
    bus.sub_in        = su;
    bus.nothing_in    = no;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.shift_in      = 16'($urandom);
    bus.sub_in        = 16'($urandom);
    bus.nothing_in    = 16'($urandom);
    prev   = bus.data_result;
    lat    = 0;
    busy_n = 0;
    held   = 1'b1;
    while (!bus.data_resultRDY && lat < 40) begin
      if (bus.busy) busy_n++;
      if (bus.data_result !== prev) held = 1'b0;
      if (pulse_mid && lat == 2 && bus.busy) begin
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = $urandom;
        bus.nothing_in    = '0;
      end
      @(posedge clock);
      #1;
      bus.ctrl_MULT = 1'b0;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(el));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(el));
    check({name, "_held_in_run"}, 64'(held), 64'(1));
    check({name, "_result"}, 64'(bus.data_result), 64'(er));
    check({name, "_exception"}, 64'(bus.data_exception), 64'(ee));
    @(posedge clock);
    #1;
    check({name, "_rdy_one_cycle"}, 64'(bus.data_resultRDY), 64'(0));
    check({name, "_idle_after"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    logic [15:0] sh1, su1, no1, sh2, su2, no2;
    logic [31:0] ra, rb, er;
    logic        ee;
    int          cyc;
    bit          held, no_rdy;

    tbl[0] = '{32'd3,          32'd5,          32'd15,         1'b0};
    tbl[1] = '{-32'sd7,        32'd6,          32'hFFFF_FFD6,  1'b0};
    tbl[2] = '{32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1};
    tbl[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    tbl[4] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0};
    tbl[5] = '{32'd2,          32'd3,          32'd6,          1'b0};
    tbl[6] = '{32'd4,          -32'sd5,        32'hFFFF_FFEC,  1'b0};
    tbl[7] = '{32'd9,          32'd1,          32'd9,          1'b0};
    tbl[8] = '{32'd9,          32'h4000_0000,  32'h4000_0000,  1'b1};
    tbl[9] = '{32'd12345,      32'd0,          32'd0,          1'b0};

    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.shift_in      = '0;
    bus.sub_in        = '0;
    bus.nothing_in    = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_result", 64'(bus.data_result), 64'(0));
    check("reset_exception", 64'(bus.data_exception), 64'(0));
    check("reset_rdy", 64'(bus.data_resultRDY), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("idle_no_start", 64'(bus.busy), 64'(0));

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc, (i % 2) == 1);
    end

    // Back-to-back with ctrl_MULT held high: 2*3 then 4*-5
    encode(32'd2 * 0 + 32'd3, sh1, su1, no1);
    encode(-32'sd5, sh2, su2, no2);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd2;
    bus.shift_in      = sh1;
    bus.sub_in        = su1;
    bus.nothing_in    = no1;
    @(posedge clock);
    #1;
    bus.data_operandA = 32'd4;
    bus.shift_in      = sh2;
    bus.sub_in        = su2;
    bus.nothing_in    = no2;
    cyc = 0;
    while (!bus.data_resultRDY && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("b2b_first_latency", 64'(cyc), 64'(exp_lat(no1)));
    check("b2b_first_result", 64'(bus.data_result), 64'(32'd6));
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    check("b2b_restart_busy", 64'(bus.busy), 64'(1));
    cyc  = 1;
    held = 1'b1;
    while (!bus.data_resultRDY && cyc < 40) begin
      if (bus.data_result !== 32'd6) held = 1'b0;
      @(posedge clock);
      #1;
      cyc++;
    end
    check("b2b_pulse_gap", 64'(cyc), 64'(exp_lat(no2) + 1));
    check("b2b_held_in_run", 64'(held), 64'(1));
    check("b2b_second_result", 64'(bus.data_result), 64'(32'hFFFF_FFEC));
    check("b2b_second_exception", 64'(bus.data_exception), 64'(0));
    @(posedge clock);
    #1;
    check("b2b_rdy_drop", 64'(bus.data_resultRDY), 64'(0));
    check("b2b_idle", 64'(bus.busy), 64'(0));

    // Reset in the middle of a run: 100*100, reset at RUN cycle 8
    encode(32'd100, sh1, su1, no1);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd100;
    bus.shift_in      = sh1;
    bus.sub_in        = su1;
    bus.nothing_in    = no1;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    repeat (7) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_result", 64'(bus.data_result), 64'(0));
    check("midrst_exception", 64'(bus.data_exception), 64'(0));
    check("midrst_rdy", 64'(bus.data_resultRDY), 64'(0));
    check("midrst_busy", 64'(bus.busy), 64'(0));
    @(negedge clock);
    reset  = 1'b0;
    no_rdy = 1'b1;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY || bus.busy) no_rdy = 1'b0;
    end
    check("midrst_no_pulse", 64'(no_rdy), 64'(1));
    run_op("after_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);

    // Randomized operations against 64-bit signed multiplication
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(0, 255)) - 32'd128;
        2:       rb = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd0;
        default: rb = 32'($signed(16'($urandom)));
      endcase
      ref_mult(ra, rb, er, ee);
      run_op($sformatf("rnd%0d", i), ra, rb, er, ee, (i % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_booth_mult_seq

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Iterative radix-4 Booth multiplier datapath. It consumes the per-group SHIFT/SUB/NOTHING control vectors produced by the Booth decoder for operand B, and the multiplicand A. It accumulates one partial product per clock over 16 groups. It returns the low 32 bits of the signed product, an overflow flag and a one-cycle ready pulse to the ALU/multdiv wrapper.

Parameters:
NGROUPS, 16, number of radix-4 groups (32-bit multiplier / 2); counter width = clog2(NGROUPS)
WIDTH, 32, operand and result width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ctrl_MULT  input  1  start request; sampled only when busy=0
data_operandA  input  32  signed multiplicand, latched on accepted start
shift_in  input  16  per-group: magnitude 2M when 1, M when 0
sub_in  input  16  per-group: negate partial product when 1
nothing_in  input  16  per-group: partial product is 0 when 1
data_result  output  32  low 32 bits of signed product
data_exception  output  1  signed overflow of the 32-bit result
data_resultRDY  output  1  one-cycle pulse when data_result/data_exception are valid
busy  output  1  high in RUN state

Behaviour:
- Reset (async, active-high): state=IDLE, acc=0, count=0, latched vectors=0. data_result=0, data_exception=0, data_resultRDY=0, busy=0. Reset mid-RUN aborts with no ready pulse.
- States: IDLE, RUN, DONE.
- IDLE: on edge with ctrl_MULT=1, latch A (sign-extended to 66 bits), shift_in, sub_in and nothing_in. Clear acc (66-bit signed) and count. Go to RUN. Otherwise stay in IDLE.
- RUN, per edge:
  - Partial product for group g=count: pp = 0 if nothing_in[g]; else mag = shift_in[g] ? (A<<1) : A, and pp = sub_in[g] ? -mag : mag.
  - acc <= acc + (pp << 2g), using two's complement at 66 bits.
  - count++. After processing g=15, go to DONE.
  - ctrl_MULT is ignored while in RUN.
- NOTHING dominates: if nothing_in[g]=1, shift_in[g] and sub_in[g] are ignored.
- DONE, on the edge entering it:
  - data_result <= acc[31:0].
  - data_exception <= 1 iff acc[63:31] is not all-equal, i.e. the 64-bit product does not fit signed 32 bits.
  - data_resultRDY is high for exactly this one cycle.
  - Next edge: if ctrl_MULT=1, start a new operation (latch, go to RUN); else go to IDLE. Back-to-back throughput is one op per 17 cycles.
- Latency: start accepted at edge k. data_resultRDY is high in the cycle after edge k+16 and low again after edge k+17.
- data_result and data_exception hold their value until the next DONE or reset. They do not change in RUN.
- busy=1 exactly in RUN. Inputs other than ctrl_MULT are don't-care outside the accepting edge.
- Control vectors follow the decoder encoding:
  - 000/111 -> NOTHING
  - 001/010 -> +M
  - 011 -> SHIFT (+2M)
  - 100 -> SHIFT+SUB (-2M)
  - 101/110 -> SUB (-M)

Optional Feature:
BOOTH_EARLY_EXIT_EN
- Defined: in RUN, if nothing_in latched bits [15:count] are all 1 after the current group is accumulated, go to DONE immediately. Result and flags are identical; latency shrinks to (index of highest non-NOTHING group + 1) cycles before DONE, with a minimum of 1 RUN cycle.
- Operand B = 0 or -1 gives 1 RUN cycle, so data_resultRDY is high in the cycle after edge k+1.
- Undefined: fixed 16 RUN cycles as above.

Test Plan:
- A=3, B=5 (vectors from decoder), pulse ctrl_MULT -> data_resultRDY exactly 16 cycles after start edge; data_result=15, data_exception=0.
- A=-7, B=6 -> data_result=0xFFFFFFD6 (-42), data_exception=0; busy high 16 cycles.
- A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE, data_exception=1. A=0x80000000, B=-1 -> data_result=0x80000000, data_exception=1.
- Start A=100, B=100; assert reset at RUN cycle 8 -> all outputs 0 immediately, no ready pulse. New op A=-1, B=-1 afterwards -> data_result=1, data_exception=0.
- ctrl_MULT held high continuously with A=2, B=3 then A=4, B=-5 -> ready pulses 17 cycles apart with results 6 then 0xFFFFFFEC. A mid-RUN pulse is ignored, and data_result is unchanged during RUN.
- With BOOTH_EARLY_EXIT_EN: A=9, B=1 -> ready in the cycle after edge k+1, result 9. A=9, B=0x40000000 -> full 16-cycle latency, result 0x40000000, data_exception=1.
